// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU op codes,
// forwarding-source enumeration and default widths.
package riscv_pkg;

   localparam int XLEN_DEFAULT   = 64;
   localparam int RIDX_W_DEFAULT = 5;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> EX handshake and operand bus. The master side is the decode
// stage plus the EX consumer; the slave side is the ID/EX register.
interface id_ex_if #(
   parameter int XLEN   = riscv_pkg::XLEN_DEFAULT,
   parameter int RIDX_W = riscv_pkg::RIDX_W_DEFAULT
);
   // upstream (decode) side
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_rs1_data;
   logic [XLEN-1:0]   id_rs2_data;
   logic [XLEN-1:0]   id_imm;
   logic [RIDX_W-1:0] id_rs1;
   logic [RIDX_W-1:0] id_rs2;
   logic [RIDX_W-1:0] id_rd;
   logic [3:0]        id_alu_op;
   logic              id_alu_src;
   logic              id_uses_rs2;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              id_reg_write;

   // downstream (execute) side
   logic              ex_valid;
   logic              ex_ready;
   logic [XLEN-1:0]   alu_src1;
   logic [XLEN-1:0]   alu_src2;
   logic [3:0]        alu_op_sel;
   logic [XLEN-1:0]   ex_store_data;
   logic [RIDX_W-1:0] ex_rd;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic              ex_reg_write;

   modport master (
      output id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_op, id_alu_src, id_uses_rs2, id_mem_read, id_mem_write,
             id_reg_write, ex_ready,
      input  id_ready, ex_valid, alu_src1, alu_src2, alu_op_sel, ex_store_data,
             ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
   );

   modport slave (
      input  id_valid, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
             id_alu_op, id_alu_src, id_uses_rs2, id_mem_read, id_mem_write,
             id_reg_write, ex_ready,
      output id_ready, ex_valid, alu_src1, alu_src2, alu_op_sel, ex_store_data,
             ex_rd, ex_mem_read, ex_mem_write, ex_reg_write
   );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass selector: MEM result beats WB result beats the value
// read from the register file; x0 is hard-wired and never bypassed.
module fwd_mux
   import riscv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int RIDX_W = RIDX_W_DEFAULT
) (
   input  logic [RIDX_W-1:0] idx_i,
   input  logic [XLEN-1:0]   reg_data_i,
   input  logic              mem_valid_i,
   input  logic [RIDX_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0]   mem_data_i,
   input  logic              wb_valid_i,
   input  logic [RIDX_W-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic [XLEN-1:0]   data_o
);

   fwd_sel_t sel;

   // pick the youngest matching producer for this source index
   always_comb begin
      sel = FWD_REG;
      if (idx_i != '0) begin
         if (mem_valid_i && (mem_rd_i == idx_i)) begin
            sel = FWD_MEM;
         end else if (wb_valid_i && (wb_rd_i == idx_i)) begin
            sel = FWD_WB;
         end
      end
   end

   // steer the chosen source onto the operand
   always_comb begin
      case (sel)
         FWD_MEM: data_o = mem_data_i;
         FWD_WB:  data_o = wb_data_i;
         default: data_o = reg_data_i;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-entry skid-less stage with load-use
// stall, flush, and combinational operand forwarding into the ALU.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = XLEN_DEFAULT,
   parameter int RIDX_W = RIDX_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              mem_fwd_valid,
   input  logic [RIDX_W-1:0] mem_fwd_rd,
   input  logic [XLEN-1:0]   mem_fwd_data,
   input  logic              wb_fwd_valid,
   input  logic [RIDX_W-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0]   wb_fwd_data,
   id_ex_if.slave            bus
);

   logic              valid_q, valid_d;
   logic              load_en;
   logic              load_use;
   logic              id_ready;
   logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
   logic [RIDX_W-1:0] rs1_q, rs2_q, rd_q;
   logic [3:0]        alu_op_q;
   logic              alu_src_q;
   logic              mem_read_q, mem_write_q, reg_write_q;
   logic [XLEN-1:0]   rs1_fwd, rs2_fwd;

   // hazard detection and next-state decision for the stage
   always_comb begin
      load_use = valid_q && mem_read_q && (rd_q != '0) && bus.id_valid &&
                 ((bus.id_rs1 == rd_q) || (bus.id_uses_rs2 && (bus.id_rs2 == rd_q)));
      id_ready = (!valid_q || bus.ex_ready) && !load_use;
      valid_d  = 1'b0;
      load_en  = 1'b0;
      if (flush) begin
         // kill wins over both hold and a same-cycle transfer-in
         valid_d = 1'b0;
      end else if (valid_q && !bus.ex_ready) begin
         valid_d = 1'b1;
      end else begin
         // stalled load-use cycles fall through here as a bubble
         load_en = bus.id_valid && id_ready;
         valid_d = load_en;
      end
   end

   // pipeline register; fields only change on an accepted transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= 1'b0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         alu_op_q    <= ALU_AND;
         alu_src_q   <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         reg_write_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load_en) begin
            rs1_data_q  <= bus.id_rs1_data;
            rs2_data_q  <= bus.id_rs2_data;
            imm_q       <= bus.id_imm;
            rs1_q       <= bus.id_rs1;
            rs2_q       <= bus.id_rs2;
            rd_q        <= bus.id_rd;
            alu_op_q    <= bus.id_alu_op;
            alu_src_q   <= bus.id_alu_src;
            mem_read_q  <= bus.id_mem_read;
            mem_write_q <= bus.id_mem_write;
            reg_write_q <= bus.id_reg_write;
         end
      end
   end

   fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs1 (
      .idx_i       (rs1_q),
      .reg_data_i  (rs1_data_q),
      .mem_valid_i (mem_fwd_valid),
      .mem_rd_i    (mem_fwd_rd),
      .mem_data_i  (mem_fwd_data),
      .wb_valid_i  (wb_fwd_valid),
      .wb_rd_i     (wb_fwd_rd),
      .wb_data_i   (wb_fwd_data),
      .data_o      (rs1_fwd)
   );

   fwd_mux #(.XLEN(XLEN), .RIDX_W(RIDX_W)) u_fwd_rs2 (
      .idx_i       (rs2_q),
      .reg_data_i  (rs2_data_q),
      .mem_valid_i (mem_fwd_valid),
      .mem_rd_i    (mem_fwd_rd),
      .mem_data_i  (mem_fwd_data),
      .wb_valid_i  (wb_fwd_valid),
      .wb_rd_i     (wb_fwd_rd),
      .wb_data_i   (wb_fwd_data),
      .data_o      (rs2_fwd)
   );

   assign bus.id_ready      = id_ready;
   assign bus.ex_valid      = valid_q;
   assign bus.alu_src1      = rs1_fwd;
   assign bus.alu_src2      = alu_src_q ? imm_q : rs2_fwd;
   assign bus.alu_op_sel    = alu_op_q;
   assign bus.ex_store_data = rs2_fwd;
   assign bus.ex_rd         = rd_q;
   // side-effecting controls are masked so a bubble can never act
   assign bus.ex_mem_read   = valid_q & mem_read_q;
   assign bus.ex_mem_write  = valid_q & mem_write_q;
   assign bus.ex_reg_write  = valid_q & reg_write_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width.
REQ-002 SHALL have parameter RIDX_W, default 5, register-index width.
REQ-003 SHALL have port clk, input, 1, single rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports id_valid input 1 and id_ready output 1, the upstream handshake.
REQ-006 SHALL have ports id_rs1_data, id_rs2_data and id_imm, each input XLEN, the decoded operands.
REQ-007 SHALL have ports id_rs1, id_rs2 and id_rd, each input RIDX_W, the register indices.
REQ-008 SHALL have ports id_alu_op input 4 (ALU op_sel code), id_alu_src input 1 (1 = imm as src2), id_uses_rs2 input 1.
REQ-009 SHALL have ports id_mem_read, id_mem_write and id_reg_write, each input 1, the control bits.
REQ-010 SHALL have ports ex_valid output 1 and ex_ready input 1, the downstream handshake.
REQ-011 SHALL have ports flush input 1, synchronous pipeline kill.
REQ-012 SHALL have ports mem_fwd_valid input 1, mem_fwd_rd input RIDX_W and mem_fwd_data input XLEN, the MEM-stage bypass.
REQ-013 SHALL have ports wb_fwd_valid input 1, wb_fwd_rd input RIDX_W and wb_fwd_data input XLEN, the WB-stage bypass.
REQ-014 SHALL have ports alu_src1 and alu_src2 output XLEN, and alu_op_sel output 4, driving the ALU.
REQ-015 SHALL have ports ex_store_data output XLEN, ex_rd output RIDX_W, and ex_mem_read, ex_mem_write, ex_reg_write output 1.

Function
REQ-016 Stage SHALL be a one-entry pipeline register: transfer in when id_valid && id_ready, out when ex_valid && ex_ready.
REQ-017 Latency SHALL be 1 cycle from ID acceptance to ex_valid=1.
REQ-018 id_ready SHALL equal (!ex_valid || ex_ready) && !load_use, combinationally.
REQ-019 load_use SHALL be ex_valid && ex_mem_read && ex_rd!=0 && id_valid && (id_rs1==ex_rd || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-020 On load_use with ex_ready=1, the register SHALL load a bubble (ex_valid=0) next cycle; with ex_ready=0, it SHALL hold.
REQ-021 While ex_valid && !ex_ready, all registered fields SHALL hold unchanged.
REQ-022 Forwarding SHALL be combinational from registered rs1/rs2 each cycle, including held cycles.
REQ-023 Forwarding priority SHALL be MEM over WB over register data; index 0 SHALL never be forwarded.
REQ-024 alu_src1 SHALL be forwarded rs1; alu_src2 SHALL be imm if alu_src=1, else forwarded rs2.
REQ-025 ex_store_data SHALL always be forwarded rs2, regardless of alu_src.
REQ-026 flush SHALL clear ex_valid next cycle, override any transfer-in that cycle, and take priority over hold.
REQ-027 When ex_valid=0, the ex_mem_read, ex_mem_write and ex_reg_write outputs SHALL read 0.

Reset
REQ-028 On rst_n low, the stage SHALL asynchronously clear ex_valid, all control bits, alu_op_sel (4'b0000), ex_rd, and all data registers.
REQ-029 After rst_n deasserts, id_ready SHALL be 1 on the first cycle.
REQ-030 A reset mid-hold SHALL discard the held instruction.

Structure
REQ-031 Package riscv_pkg SHALL hold the ALU op codes (AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100), the fwd_sel_t enum {FWD_REG, FWD_MEM, FWD_WB}, and the XLEN default.
REQ-032 Sub-module fwd_mux SHALL be instantiated twice (rs1, rs2): inputs index, reg data and two bypasses; output selected data.

Verification
REQ-033 Scenario: ADD with rs1=3 (10), rs2=4 (20), ex_ready=1 -> next cycle ex_valid=1, alu_src1=10, alu_src2=20, alu_op_sel=0010.
REQ-034 Scenario: held entry rs1=5, mem_fwd {1,5,0xAA}, wb_fwd {1,5,0xBB} -> alu_src1=0xAA; drop mem_fwd_valid -> 0xBB.
REQ-035 Scenario: held entry rs1=0, mem_fwd {1,0,0xFF}, reg data 0 -> alu_src1=0.
REQ-036 Scenario: EX holds load rd=7, ID presents rs2=7 with id_uses_rs2=1 -> id_ready=0, one bubble, then accept.
REQ-037 Scenario: ex_valid=1, ex_ready=0 for 3 cycles -> outputs stable; flush in cycle 2 -> ex_valid=0 next cycle.
REQ-038 Scenario: rst_n low mid-hold -> ex_valid=0, controls=0 immediately, without waiting for a clock edge.
